scope_trace_renderer: RTL
=========================

// Module: scope_trace_renderer
// PURPOSE
//  Pixel source for the LCD scope; sits directly upstream of the LT24Display driver and
//  replaces its free-running test-pattern logic. Waits for a trigger on the incoming ADC
//  sample stream, then captures one screen of samples (one per LCD row). It rasterises
//  the captured trace, a grid and a black background into the driver's xAddr/yAddr/
//  pixelData/pixelWrite interface under pixelReady backpressure.
// PARAMETERS
//  LCD_W     240  display width in pixels (x axis = sample amplitude)
//  LCD_H     320  display height in pixels (y axis = time, one sample per row)
//  SAMPLE_W  8    width of sampleData / trigLevel
//  GRID_DIV  40   grid line pitch in pixels, both axes
// PORTS
//  clock       in   1   system clock, 50 MHz
//  rstApp      in   1   asynchronous, active-high reset
//  runEn       in   1   1 = re-arm after each frame; 0 = hold in ARM
//  sampleValid in   1   one-cycle strobe: sampleData is valid this cycle
//  sampleData  in   8   unsigned ADC sample
//  trigLevel   in   8   rising-edge trigger threshold
//  pixReady    in   1   driver accepts pixel this cycle (pixWrite && pixReady = transfer)
//  pixWrite    out  1   pixel valid
//  xAddr       out  8   pixel column, 0..LCD_W-1
//  yAddr       out  9   pixel row, 0..LCD_H-1
//  pixData     out  16  RGB565 colour
//  frameDone   out  1   one-cycle pulse after the last pixel of a frame is accepted
//  busy        out  1   1 in every state except ARM
// BEHAVIOUR
//  Reset: async to ARM; pixWrite=0, xAddr=0, yAddr=0, pixData=0, frameDone=0, busy=0,
//   wrPtr=0, prevValid=0. Sample RAM is not cleared. Reset mid-frame abandons the frame.
//  FSM:
//   ARM: clears wrPtr and prevValid; moves to WAIT_TRIG when runEn=1.
//   WAIT_TRIG: on each sampleValid, latch prev=sampleData and set prevValid.
//    Trigger when prevValid && prev<trigLevel && sampleData>=trigLevel.
//    The triggering sample is written to RAM[0], wrPtr=1, next state CAPTURE.
//   CAPTURE: each sampleValid writes RAM[wrPtr] and increments wrPtr.
//    The write to index LCD_H-1 moves to FETCH with y=0.
//   FETCH: 2 cycles, pixWrite=0. Reads RAM[y] and RAM[y-1] (sync read, 1-cycle latency).
//    y=0 uses RAM[0] for both. Clamp each read to min(s, LCD_W-1).
//    Store lo=min and hi=max of the two clamped values. Next state DRAW with x=0.
//   DRAW: pixWrite=1. xAddr=x, yAddr=y, pixData=f(x,y,lo,hi); all held stable until accepted.
//    On accept: x++. If accepted x==LCD_W-1: x=0, y++, go FETCH.
//    If also y==LCD_H-1: go DONE instead.
//   DONE: pixWrite=0, frameDone=1 for exactly one cycle, then ARM.
//  Colour f, priority order:
//   trace  16'h07E0 if lo<=x<=hi
//   grid   16'h4208 if gx==0 || gy==0
//   else   16'h0000 background
//  gx/gy: wrapping 0..GRID_DIV-1 counters that track x/y. No divider or modulo.
//  sampleValid is ignored in ARM, FETCH, DRAW and DONE. The sample stream is never stalled.
//  Raster order: x inner, y outer. Exactly LCD_W*LCD_H transfers per frame, none dropped or repeated.
//  All widths unsigned. Comparisons on zero-extended 8-bit values.
// STRUCTURE
//  scope_pkg: LCD_W, LCD_H, GRID_DIV defaults; colour constants TRACE/GRID/BG; state encoding.
//  Sub-module sample_ram: simple dual-port LCD_H x SAMPLE_W RAM.
//   One write port (CAPTURE), one sync read port (FETCH). Infers M10K.
//  Top level holds the FSM, raster/grid counters, trigger compare and colour mux.
// TESTING
//  1 Reset: assert rstApp mid-DRAW at y=100 -> same-cycle pixWrite=0, x/yAddr=0, pixData=0, busy=0.
//    On release with runEn=1 -> ARM then WAIT_TRIG.
//  2 Trigger: trigLevel=128; stream 100,120,127,128 -> RAM[0]=128.
//    Stream 140,100,200 gives no trigger at 100. First 200 after ARM alone gives no trigger (prevValid=0).
//  3 Flat trace: 320 samples of 60, pixReady=1 -> every row: x=60 is 07E0; x=0,40 are 4208; x=1 is 0000.
//    Rows 0,40,80 are grey except x=60. Exactly 76800 transfers, one frameDone pulse.
//  4 Line fill and clamp: RAM[9]=50, RAM[10]=55 -> row 10 x=50..55 green.
//    Sample 250 -> x=239 green.
//  5 Backpressure: random pixReady (~30% duty) -> outputs held while low.
//    Scoreboard sees the same 76800 (x,y,data) tuples as test 3.
//  6 Busy drop: sampleValid every cycle through FETCH/DRAW -> RAM unchanged.
//    With runEn=0 after DONE, the block stays in ARM.

Source files
------------

// File: rtl/scope_trace_renderer_pkg.sv
// ============================================================================
//  scope_trace_renderer_pkg
//  Shared screen geometry, colours, FSM encoding and colour helper.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package scope_trace_renderer_pkg;

  localparam int DEF_LCD_W    = 240;
  localparam int DEF_LCD_H    = 320;
  localparam int DEF_SAMPLE_W = 8;
  localparam int DEF_GRID_DIV = 40;

  localparam logic [15:0] COLOUR_TRACE = 16'h07E0;
  localparam logic [15:0] COLOUR_GRID  = 16'h4208;
  localparam logic [15:0] COLOUR_BG    = 16'h0000;

  typedef enum logic [2:0] {
    ST_ARM       = 3'd0,
    ST_WAIT_TRIG = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_FETCH     = 3'd3,
    ST_DRAW      = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  // Trace wins over grid, grid wins over background.
  function automatic logic [15:0] pix_colour(input logic [7:0] x,
                                             input logic [7:0] lo,
                                             input logic [7:0] hi,
                                             input logic       on_grid);
    if ((x >= lo) && (x <= hi)) return COLOUR_TRACE;
    if (on_grid)                return COLOUR_GRID;
    return COLOUR_BG;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scope_trace_renderer_sample_ram.sv
// ============================================================================
//  scope_trace_renderer_sample_ram
//  Simple dual-port sample store: one write port, one registered read port.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module scope_trace_renderer_sample_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data_q
);

  // Full power-of-two depth so the row pointer indexes without truncation.
  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

endmodule

`default_nettype wire

// File: rtl/scope_trace_renderer.sv
// ============================================================================
//  scope_trace_renderer
//  Triggered single-screen capture of an ADC stream, rasterised as trace+grid.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module scope_trace_renderer
  import scope_trace_renderer_pkg::*;
#(
  parameter int LCD_W    = DEF_LCD_W,
  parameter int LCD_H    = DEF_LCD_H,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int GRID_DIV = DEF_GRID_DIV
) (
  input  logic                clock,
  input  logic                rstApp,
  input  logic                runEn,
  input  logic                sampleValid,
  input  logic [SAMPLE_W-1:0] sampleData,
  input  logic [SAMPLE_W-1:0] trigLevel,
  input  logic                pixReady,
  output logic                pixWrite,
  output logic [7:0]          xAddr,
  output logic [8:0]          yAddr,
  output logic [15:0]         pixData,
  output logic                frameDone,
  output logic                busy
);

  localparam logic [7:0] X_LAST  = 8'(LCD_W - 1);
  localparam logic [8:0] Y_LAST  = 9'(LCD_H - 1);
  localparam logic [7:0] GX_LAST = 8'(GRID_DIV - 1);
  localparam logic [7:0] GY_LAST = 8'(GRID_DIV - 1);

  function automatic logic [7:0] clamp_x(input logic [SAMPLE_W-1:0] s);
    if (32'(s) >= LCD_W) return X_LAST;
    return 8'(s);
  endfunction

  state_t                state_q, state_d;
  logic [8:0]            wr_ptr_q, wr_ptr_d;
  logic [SAMPLE_W-1:0]   prev_q, prev_d;
  logic                  prev_valid_q, prev_valid_d;
  logic                  fetch_ph_q, fetch_ph_d;
  logic [7:0]            x_q, x_d;
  logic [8:0]            y_q, y_d;
  logic [7:0]            gx_q, gx_d;
  logic [7:0]            gy_q, gy_d;
  logic [7:0]            cur_q, cur_d;
  logic [7:0]            lo_q, lo_d;
  logic [7:0]            hi_q, hi_d;
  logic                  pix_write_q, pix_write_d;
  logic [15:0]           pix_data_q, pix_data_d;
  logic                  frame_done_q, frame_done_d;
  logic                  busy_q, busy_d;

  logic                  ram_we;
  logic [8:0]            ram_waddr;
  logic                  ram_re;
  logic [SAMPLE_W-1:0]   ram_rdata;

  logic                  trig_hit;
  logic [7:0]            cur_w, prev_w, lo_w, hi_w;
  logic [7:0]            x_next, gx_next, gy_next;

  scope_trace_renderer_sample_ram #(
    .DATA_W (SAMPLE_W),
    .ADDR_W (9)
  ) u_sample_ram (
    .clock     (clock),
    .wr_en     (ram_we),
    .wr_addr   (ram_waddr),
    .wr_data   (sampleData),
    .rd_en     (ram_re),
    .rd_addr   (y_q),
    .rd_data_q (ram_rdata)
  );

  assign trig_hit = prev_valid_q && (prev_q < trigLevel) && (sampleData >= trigLevel);

  // Row y-1 was fetched as "current" on the previous row, so one read per row suffices.
  assign cur_w  = clamp_x(ram_rdata);
  assign prev_w = (y_q == 9'd0) ? cur_w : cur_q;
  assign lo_w   = (cur_w < prev_w) ? cur_w : prev_w;
  assign hi_w   = (cur_w < prev_w) ? prev_w : cur_w;

  assign x_next  = x_q + 8'd1;
  assign gx_next = (gx_q == GX_LAST) ? 8'd0 : gx_q + 8'd1;
  assign gy_next = (gy_q == GY_LAST) ? 8'd0 : gy_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    fetch_ph_d   = fetch_ph_q;
    x_d          = x_q;
    y_d          = y_q;
    gx_d         = gx_q;
    gy_d         = gy_q;
    cur_d        = cur_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    pix_write_d  = pix_write_q;
    pix_data_d   = pix_data_q;
    frame_done_d = 1'b0;
    ram_we       = 1'b0;
    ram_waddr    = wr_ptr_q;
    ram_re       = 1'b0;

    unique case (state_q)
      ST_ARM: begin
        wr_ptr_d     = 9'd0;
        prev_valid_d = 1'b0;
        if (runEn) state_d = ST_WAIT_TRIG;
      end

      ST_WAIT_TRIG: begin
        if (sampleValid) begin
          prev_d       = sampleData;
          prev_valid_d = 1'b1;
          if (trig_hit) begin
            ram_we    = 1'b1;
            ram_waddr = 9'd0;
            wr_ptr_d  = 9'd1;
            state_d   = ST_CAPTURE;
          end
        end
      end

      ST_CAPTURE: begin
        if (sampleValid) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 9'd1;
          if (wr_ptr_q == Y_LAST) begin
            state_d    = ST_FETCH;
            fetch_ph_d = 1'b0;
            y_d        = 9'd0;
            gy_d       = 8'd0;
          end
        end
      end

      ST_FETCH: begin
        if (!fetch_ph_q) begin
          ram_re     = 1'b1;
          fetch_ph_d = 1'b1;
        end else begin
          fetch_ph_d  = 1'b0;
          cur_d       = cur_w;
          lo_d        = lo_w;
          hi_d        = hi_w;
          x_d         = 8'd0;
          gx_d        = 8'd0;
          pix_write_d = 1'b1;
          pix_data_d  = pix_colour(8'd0, lo_w, hi_w, 1'b1);
          state_d     = ST_DRAW;
        end
      end

      ST_DRAW: begin
        if (pixReady) begin
          if (x_q == X_LAST) begin
            pix_write_d = 1'b0;
            x_d         = 8'd0;
            gx_d        = 8'd0;
            if (y_q == Y_LAST) begin
              y_d          = 9'd0;
              gy_d         = 8'd0;
              frame_done_d = 1'b1;
              state_d      = ST_DONE;
            end else begin
              y_d     = y_q + 9'd1;
              gy_d    = gy_next;
              state_d = ST_FETCH;
            end
          end else begin
            x_d        = x_next;
            gx_d       = gx_next;
            pix_data_d = pix_colour(x_next, lo_q, hi_q,
                                    (gx_next == 8'd0) || (gy_q == 8'd0));
          end
        end
      end

      ST_DONE: begin
        state_d = ST_ARM;
      end

      default: begin
        state_d     = ST_ARM;
        pix_write_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_ARM);
  end

  always_ff @(posedge clock or posedge rstApp) begin
    if (rstApp) begin
      state_q      <= ST_ARM;
      wr_ptr_q     <= 9'd0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      fetch_ph_q   <= 1'b0;
      x_q          <= 8'd0;
      y_q          <= 9'd0;
      gx_q         <= 8'd0;
      gy_q         <= 8'd0;
      cur_q        <= 8'd0;
      lo_q         <= 8'd0;
      hi_q         <= 8'd0;
      pix_write_q  <= 1'b0;
      pix_data_q   <= 16'd0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      fetch_ph_q   <= fetch_ph_d;
      x_q          <= x_d;
      y_q          <= y_d;
      gx_q         <= gx_d;
      gy_q         <= gy_d;
      cur_q        <= cur_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      pix_write_q  <= pix_write_d;
      pix_data_q   <= pix_data_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign pixWrite  = pix_write_q;
  assign xAddr     = x_q;
  assign yAddr     = y_q;
  assign pixData   = pix_data_q;
  assign frameDone = frame_done_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire
